// File: rtl/qpp_ind_gen.sv
// qpp_ind_gen: QPP interleaver address generator.
// It emits the sequential index i and pi(i) = (f1*i + f2*i^2) mod K using only modular adds.
module qpp_ind_gen #(
  parameter int W    = 14,
  parameter int K0   = 1056,
  parameter int F1_0 = 17,
  parameter int F2_0 = 66,
  parameter int K1   = 6144,
  parameter int F1_1 = 263,
  parameter int F2_1 = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         k,
  input  logic         stall,
  input  logic         abort,
  output logic [W-1:0] idx_out,
  output logic [W-1:0] addr_out,
  output logic         valid,
  output logic         last,
  output logic         busy,
  output logic         done
);
  localparam logic [W-1:0] KA = W'(K0);
  localparam logic [W-1:0] KB = W'(K1);
  localparam logic [W-1:0] GA = W'((F1_0 + F2_0) % K0);
  localparam logic [W-1:0] GB = W'((F1_1 + F2_1) % K1);
  localparam logic [W-1:0] DA = W'((2 * F2_0) % K0);
  localparam logic [W-1:0] DB = W'((2 * F2_1) % K1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic m_q, m_d;
  logic [W-1:0] idx_q, idx_d, pi_q, pi_d, g_q, g_d;
  logic [W-1:0] kk, dg;
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, n}) ? W'(s - {1'b0, n}) : s[W-1:0];
  endfunction
  assign kk       = m_q ? KB : KA;
  assign dg       = m_q ? DB : DA;
  assign idx_out  = idx_q;
  assign addr_out = pi_q;
  assign valid    = (state_q == RUN) && !stall;
  assign last     = valid && (idx_q == kk - 1'b1);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    idx_d   = idx_q;
    pi_d    = pi_q;
    g_d     = g_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        m_d     = k;
        idx_d   = '0;
        pi_d    = '0;
        g_d     = k ? GB : GA;
      end
    end else if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      pi_d    = '0;
      g_d     = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (!stall) begin
      if (idx_q == kk - 1'b1) state_d = DONE;
      else begin
        idx_d = idx_q + 1'b1;
        pi_d  = add_mod(pi_q, g_q, kk);
        g_d   = add_mod(g_q, dg, kk);
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= 1'b0;
      idx_q   <= '0;
      pi_q    <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
    end
  end
endmodule

// File: doc/qpp_ind_gen.md
# qpp_ind_gen

Parametrised interleaver address generator for the turbo coder's internal interleaver. Supersedes the plain index counter: per block it emits both the sequential index i and the QPP-interleaved address π(i) = (f1·i + f2·i²) mod K. It computes π(i) incrementally with modular adds only, so no multipliers are used. It sits between the coder control FSM and the interleaver RAM address ports, and supports two block-size modes selected per block.

## Interface

Parameters:
- `W`, 14: index/address width; must satisfy 2^W > max(K0, K1).
- `K0`, 1056: block size, mode 0.
- `F1_0`, 17: QPP f1, mode 0.
- `F2_0`, 66: QPP f2, mode 0.
- `K1`, 6144: block size, mode 1.
- `F1_1`, 263: QPP f1, mode 1.
- `F2_1`, 480: QPP f2, mode 1.

Ports:
- `clock` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-low. Clears all state immediately when low.
- `start` in 1: request a new block. Sampled only in IDLE.
- `k` in 1: mode select. 0 selects K0/F1_0/F2_0; 1 selects K1/F1_1/F2_1. Latched on accepted `start`.
- `stall` in 1: freeze the sequence for this cycle.
- `abort` in 1: synchronous abandon of the current block.
- `idx_out` out W: sequential index i.
- `addr_out` out W: interleaved address π(i).
- `valid` out 1: `idx_out`/`addr_out` are meaningful this cycle.
- `last` out 1: `valid` and `idx_out` == K−1.
- `busy` out 1: state is RUN or DONE.
- `done` out 1: one-cycle pulse after the final element.

## Operation

- States are IDLE, RUN and DONE. Reset value: IDLE, and every output is 0.
- Internal registers: `idx`, `pi`, `g`, each W bits; latched mode `m`; and the selected K, 2·f2 mod K, and (f1+f2) mod K, all derived from `m`.
- Recursion:
  - π(0) = 0.
  - g(0) = (f1+f2) mod K.
  - π(i+1) = (π(i)+g(i)) mod K.
  - g(i+1) = (g(i) + 2·f2 mod K) mod K.
- Modular add: operands are < K. Form a W+1-bit sum and subtract K if sum ≥ K. The result is always < K. No other arithmetic is allowed.
- IDLE:
  - `start`=1 latches `m`←`k`, `idx`←0, `pi`←0, `g`←g(0) of the selected mode, and moves to RUN.
  - `stall` and `abort` are ignored in IDLE.
- RUN, checked in priority order:
  1. `abort`=1: go to IDLE and clear `idx`/`pi`/`g`. No `done`.
  2. `stall`=1: hold all registers.
  3. `idx`==K−1: go to DONE.
  4. Otherwise advance `idx`+1 and `pi`/`g` per the recursion.
- `start` is ignored in RUN and DONE. `k` changes after acceptance have no effect on the current block.
- DONE: lasts exactly one cycle, then IDLE. `abort` in DONE also goes to IDLE.
- `idx_out`=`idx` and `addr_out`=`pi` in all states. They are held at their last values outside RUN, and are zero after reset or abort.
- Outputs:
  - `valid` = (state==RUN) && !`stall`.
  - `last` = `valid` && `idx`==K−1.
  - `done` = (state==DONE).
  - `busy` = (state≠IDLE).
- Reset mid-block: immediate return to IDLE with all outputs 0. There is no resume.

## Timing

- Latency: `start` sampled at edge t0 gives `valid`=1 with i=0, π=0 during the cycle after t0.
- Throughput: one element per unstalled cycle. An unstalled block gives exactly K `valid` cycles.
- `last` coincides with the K-th valid element.
- `done` is high in the cycle after `last`. The block returns to IDLE one cycle later. The earliest next `start` is accepted at the edge ending the DONE cycle's successor, i.e. while in IDLE.
- Stall is combinational on `valid`. The element presented under stall is re-presented, unchanged, on the next unstalled cycle.
- Abort takes effect at the next edge. The abort cycle itself still shows `valid` if unstalled.

## Test plan

- Mode 0 (k=0) smoke test: start, then no stall.
  - Addresses start 0, 83, 298.
  - The K0 = 1056 valid cycles end with idx 1055 / addr 49 and `last`=1.
  - `done` pulses the next cycle.
  - The set of 1056 addresses is a permutation of 0..1055.
- Mode 1 (k=1): addresses start 0, 743, 2446. The final element is idx 6143 / addr 217. All 6144 addresses are distinct.
- Random `stall` on a mode 0 block: the address sequence is identical to the unstalled run. `valid` is low exactly on stall cycles. The total valid count is 1056.
- `abort` at idx 500: the next edge gives IDLE with outputs 0 and no `done`. A new start replays from 0.
- `reset` asserted low mid-block for one cycle: all outputs drop to 0 asynchronously, before the next edge. `start` is ignored while `reset` is low.
- `start` pulsed and `k` toggled during RUN: both ignored, and the block completes in its latched mode. `start` held high continuously gives back-to-back blocks separated by DONE plus one IDLE cycle.
